// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one SPI Master between NUM_REQ requesters: grant, timed start window, capture, done.
// Optional macro SPI_ARB_SLAVE_CHECK_EN rejects a winner whose slave select is 2'b11 and pulses err instead.
module spi_master_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int XFER_CYCLES = 9,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   req_slave,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [7:0]             rx_data,
    output logic                   busy,
    output logic                   m_start,
    output logic [1:0]             m_slave_select,
    output logic [7:0]             m_data_to_send,
    input  logic [7:0]             m_data_received
`ifdef SPI_ARB_SLAVE_CHECK_EN
    ,
    output logic                   err
`endif
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, XFER, CAPTURE, GAP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [7:0]         rx_q, rx_d;
    logic               busy_q, busy_d;
    logic               start_q, start_d;
    logic [1:0]         ss_q, ss_d;
    logic [7:0]         dts_q, dts_d;
`ifdef SPI_ARB_SLAVE_CHECK_EN
    logic               skip_q, skip_d;
    logic               err_q, err_d;
`endif

    logic               found;
    logic [PTR_W-1:0]   win;
    logic [1:0]         win_slave;
    logic [7:0]         win_data;

    // First requester after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[PTR_W'(idx)]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        win_slave = req_slave[2*int'(win) +: 2];
        win_data  = req_data[8*int'(win) +: 8];
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        rx_d     = rx_q;
        start_d  = start_q;
        ss_d     = ss_q;
        dts_d    = dts_q;
`ifdef SPI_ARB_SLAVE_CHECK_EN
        skip_d   = skip_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    ss_d       = win_slave;
                    dts_d      = win_data;
                    rr_ptr_d   = win;
                    cnt_d      = '0;
                    start_d    = 1'b1;
                    state_d    = XFER;
`ifdef SPI_ARB_SLAVE_CHECK_EN
                    // No chip-select line: hold the grant one cycle, then report instead of transferring.
                    if (win_slave == 2'b11) begin
                        start_d = 1'b0;
                        skip_d  = 1'b1;
                        state_d = CAPTURE;
                    end
`endif
                end
            end
            XFER: begin
                if (cnt_q == CNT_W'(XFER_CYCLES - 1)) begin
                    start_d = 1'b0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
`ifdef SPI_ARB_SLAVE_CHECK_EN
                if (skip_q) err_d = 1'b1;
                else        rx_d  = m_data_received;
                skip_d = 1'b0;
`else
                rx_d = m_data_received;
`endif
                done_d  = gnt_q;
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = IDLE;
                else                                 cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= PTR_W'(NUM_REQ - 1);
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            rx_q     <= '0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            ss_q     <= '0;
            dts_q    <= '0;
`ifdef SPI_ARB_SLAVE_CHECK_EN
            skip_q   <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rx_q     <= rx_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            ss_q     <= ss_d;
            dts_q    <= dts_d;
`ifdef SPI_ARB_SLAVE_CHECK_EN
            skip_q   <= skip_d;
            err_q    <= err_d;
`endif
        end
    end

    assign gnt            = gnt_q;
    assign done           = done_q;
    assign rx_data        = rx_q;
    assign busy           = busy_q;
    assign m_start        = start_q;
    assign m_slave_select = ss_q;
    assign m_data_to_send = dts_q;
`ifdef SPI_ARB_SLAVE_CHECK_EN
    assign err            = err_q;
`endif

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter: expected (requester, rx byte) pushed at stimulus, popped on done.
module tb_spi_master_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req;
    logic [5:0] req_slave;
    logic [23:0] req_data;
    logic [2:0] gnt;
    logic [2:0] done;
    logic [7:0] rx_data;
    logic       busy;
    logic       m_start;
    logic [1:0] m_slave_select;
    logic [7:0] m_data_to_send;
    logic [7:0] m_data_received;
`ifdef SPI_ARB_SLAVE_CHECK_EN
    logic       err;
`endif

    typedef struct {
        int         id;
        logic [7:0] rx;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   run = 0;
    logic [2:0] gnt_mask;

    always #5 clk = ~clk;

    // Slave model behind the Master: reply byte is a fixed function of the byte sent.
    function automatic logic [7:0] resp(input logic [7:0] d);
        case (d)
            8'h53:   return 8'h09;
            8'h3C:   return 8'h98;
            default: return d ^ 8'hC3;
        endcase
    endfunction

    assign m_data_received = resp(m_data_to_send);

    spi_master_arbiter #(.NUM_REQ(3), .XFER_CYCLES(9), .GAP_CYCLES(1)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_slave(req_slave),
        .req_data(req_data),
        .gnt(gnt),
        .done(done),
        .rx_data(rx_data),
        .busy(busy),
        .m_start(m_start),
        .m_slave_select(m_slave_select),
        .m_data_to_send(m_data_to_send),
        .m_data_received(m_data_received)
`ifdef SPI_ARB_SLAVE_CHECK_EN
        ,
        .err(err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: one-hot grant, start window length, scoreboard pop on done.
    always @(negedge clk) begin
        if (reset) begin
            run = 0;
        end else begin
            check("gnt_onehot", 32'($countones(gnt) <= 1), 1);
            if (m_start) begin
                run++;
            end else if (run != 0) begin
                check("start_len", run, 9);
                run = 0;
            end
            if (done != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_id", done, 32'(1 << e.id));
                    check("rx_data", rx_data, e.rx);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_rx", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_start", m_start, 0);
        check("rst_ss", m_slave_select, 0);
        check("rst_dts", m_data_to_send, 0);
        reset = 1'b0;
    endtask

    // Runs until ndone done pulses seen; checks low gap between consecutive start windows.
    task automatic serve(input int ndone, input bit drop);
        int got = 0;
        int low = 0;
        bit seen = 1'b0;
        bit prev = 1'b0;
        for (int c = 0; c < 400 && got < ndone; c++) begin
            @(negedge clk);
            gnt_mask = gnt_mask | gnt;
            if (m_start && !prev && seen) check("start_gap", low, 3);
            if (m_start) begin
                seen = 1'b1;
                low  = 0;
            end else begin
                low++;
            end
            prev = m_start;
            if (done != 3'b000) begin
                got++;
                if (drop) req = req & ~done;
            end
        end
        check("serve_count", got, ndone);
    endtask

    task automatic wait_start();
        for (int c = 0; c < 20 && !m_start; c++) @(negedge clk);
        check("start_seen", m_start, 1);
    endtask

    initial begin
        int first;
        int highs;
        int dcyc;
        req       = 3'b000;
        req_slave = 6'b000000;
        req_data  = 24'h0;
        do_reset();

        // Single request: latency, window length, done timing.
        req_slave[1:0] = 2'd1;
        req_data[7:0]  = 8'h53;
        exp_q.push_back('{id: 0, rx: 8'h09});
        req   = 3'b001;
        first = -1;
        highs = 0;
        dcyc  = -1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) check("s1_busy", busy, 1);
            if (m_start) begin
                if (first < 0) first = c;
                highs++;
                check("s1_dts", m_data_to_send, 8'h53);
                check("s1_ss", m_slave_select, 1);
            end
            if (done[0]) begin
                dcyc   = c;
                req[0] = 1'b0;
            end
        end
        check("s1_start_lat", first, 1);
        check("s1_start_cnt", highs, 9);
        check("s1_done_cyc", dcyc, 11);

        // Contention from reset: 0,1,2,0.
        req_slave = {2'd2, 2'd1, 2'd0};
        req_data  = {8'h71, 8'h3C, 8'h53};
        exp_q.push_back('{id: 0, rx: 8'h09});
        exp_q.push_back('{id: 1, rx: 8'h98});
        exp_q.push_back('{id: 2, rx: resp(8'h71)});
        exp_q.push_back('{id: 0, rx: 8'h09});
        req = 3'b111;
        do_reset();
        serve(4, 1'b0);

        // rr_ptr now 0: requester 2 before 0, requester 1 idle.
        gnt_mask = 3'b000;
        exp_q.push_back('{id: 2, rx: resp(8'h71)});
        exp_q.push_back('{id: 0, rx: 8'h09});
        req = 3'b101;
        serve(2, 1'b1);
        check("rr_no_gnt1", gnt_mask[1], 0);

        // Inputs changed after grant must not reach the Master.
        exp_q.push_back('{id: 1, rx: 8'h98});
        req = 3'b010;
        wait_start();
        repeat (3) @(negedge clk);
        req_data[15:8] = 8'hFF;
        req_slave[3:2] = 2'd0;
        repeat (2) @(negedge clk);
        check("hold_dts", m_data_to_send, 8'h3C);
        check("hold_ss", m_slave_select, 1);
        serve(1, 1'b1);
        req_data[15:8] = 8'h3C;
        req_slave[3:2] = 2'd1;

        // Reset at XFER counter 4: abort, then rr_ptr restarts at 2 so 0 beats 1.
        req = 3'b001;
        wait_start();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_start", m_start, 0);
        check("abort_gnt", gnt, 0);
        check("abort_busy", busy, 0);
        check("abort_rx", rx_data, 0);
        check("abort_done", done, 0);
        req = 3'b011;
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back('{id: 0, rx: 8'h09});
        exp_q.push_back('{id: 1, rx: 8'h98});
        serve(2, 1'b1);

        // Slave select 2'b11 on requester 2.
        req_slave[5:4] = 2'b11;
        req_data[23:16] = 8'hA7;
`ifdef SPI_ARB_SLAVE_CHECK_EN
        begin
            int g = -1;
            int d = -1;
            int errs = 0;
            bit st = 1'b0;
            repeat (2) @(negedge clk);
            exp_q.push_back('{id: 2, rx: 8'h98});
            req = 3'b100;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (m_start) st = 1'b1;
                if (gnt[2] && g < 0) g = c;
                if (err) begin
                    errs++;
                    check("err_with_done", done[2], 1);
                end
                if (done[2]) begin
                    d = c;
                    req[2] = 1'b0;
                end
            end
            check("err_no_start", st, 0);
            check("err_gnt_cyc", g, 1);
            check("err_done_cyc", d, 2);
            check("err_pulses", errs, 1);
        end
`else
        exp_q.push_back('{id: 2, rx: resp(8'hA7)});
        req = 3'b100;
        wait_start();
        check("ss11_pass", m_slave_select, 2'b11);
        check("ss11_dts", m_data_to_send, 8'hA7);
        serve(1, 1'b1);
`endif

        repeat (5) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
